// File: rtl/div_issue_ctrl_if.sv
// Request/response handshake bundle for the divider issue/capture stage.
// The master modport is the requester/consumer side; slave is the stage itself.
interface div_issue_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_dividend;
  logic [WIDTH-1:0] req_divisor;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_quot;
  logic [WIDTH-1:0] rsp_rem;
  logic             rsp_dbz;

  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready,
    input  req_ready, rsp_valid, rsp_quot, rsp_rem, rsp_dbz
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
    output req_ready, rsp_valid, rsp_quot, rsp_rem, rsp_dbz
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// Issue/capture stage around a combinational divider: registers operands, waits SETTLE
// cycles, captures quotient/remainder/dbz and presents them on a valid/ready response.
module div_issue_ctrl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  div_issue_ctrl_if.slave    io_bus,
  output logic [WIDTH-1:0]   o_div_in1,
  output logic [WIDTH-1:0]   o_div_in2,
  input  logic [WIDTH-1:0]   i_div_out,
  input  logic               i_div_dbz,
  output logic [CNT_W-1:0]   o_dbz_count
);

  localparam int unsigned WaitW = $clog2(SETTLE + 1);
  localparam int unsigned ProdW = 2 * WIDTH;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e             r_state, w_state_d;
  logic [WaitW-1:0]   r_wait, w_wait_d;
  logic [WIDTH-1:0]   r_in1, w_in1_d;
  logic [WIDTH-1:0]   r_in2, w_in2_d;
  logic [WIDTH-1:0]   r_quot, w_quot_d;
  logic [WIDTH-1:0]   r_rem, w_rem_d;
  logic               r_dbz, w_dbz_d;
  logic [CNT_W-1:0]   r_dbz_cnt, w_dbz_cnt_d;
  logic [WIDTH-1:0]   w_rem;

  // Remainder from the divider's quotient, formed at double width then truncated.
  assign w_rem = WIDTH'(ProdW'(r_in1) - ProdW'(i_div_out) * ProdW'(r_in2));

  always_comb begin
    w_state_d   = r_state;
    w_wait_d    = r_wait;
    w_in1_d     = r_in1;
    w_in2_d     = r_in2;
    w_quot_d    = r_quot;
    w_rem_d     = r_rem;
    w_dbz_d     = r_dbz;
    w_dbz_cnt_d = r_dbz_cnt;

    unique case (r_state)
      StIdle: begin
        if (io_bus.req_valid) begin
          w_in1_d   = io_bus.req_dividend;
          w_in2_d   = io_bus.req_divisor;
          w_wait_d  = WaitW'(SETTLE);
          w_state_d = StWait;
        end
      end
      StWait: begin
        if (r_wait == WaitW'(1)) begin
          w_state_d = StResp;
          if (i_div_dbz) begin
            // Divider output is undefined for a zero divisor, so it is not used.
            w_quot_d = {WIDTH{1'b1}};
            w_rem_d  = r_in1;
            w_dbz_d  = 1'b1;
            if (r_dbz_cnt != {CNT_W{1'b1}}) begin
              w_dbz_cnt_d = r_dbz_cnt + CNT_W'(1);
            end
          end else begin
            w_quot_d = i_div_out;
            w_rem_d  = w_rem;
            w_dbz_d  = 1'b0;
          end
        end else begin
          w_wait_d = r_wait - WaitW'(1);
        end
      end
      StResp: begin
        if (io_bus.rsp_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_wait    <= '0;
      r_in1     <= '0;
      r_in2     <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_dbz     <= 1'b0;
      r_dbz_cnt <= '0;
    end else begin
      r_state   <= w_state_d;
      r_wait    <= w_wait_d;
      r_in1     <= w_in1_d;
      r_in2     <= w_in2_d;
      r_quot    <= w_quot_d;
      r_rem     <= w_rem_d;
      r_dbz     <= w_dbz_d;
      r_dbz_cnt <= w_dbz_cnt_d;
    end
  end

  assign io_bus.req_ready = (r_state == StIdle);
  assign io_bus.rsp_valid = (r_state == StResp);
  assign io_bus.rsp_quot  = r_quot;
  assign io_bus.rsp_rem   = r_rem;
  assign io_bus.rsp_dbz   = r_dbz;
  assign o_div_in1        = r_in1;
  assign o_div_in2        = r_in2;
  assign o_dbz_count      = r_dbz_cnt;

endmodule
